// File: rtl/mem_traffic_pkg.sv
// Shared types and constants for the memory traffic generator.
package mem_traffic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    // Bit positions inside err_code.
    localparam int ERR_STALL = 0;
    localparam int ERR_DRAIN = 1;
    localparam int ERR_RESP  = 2;

    // req_type encoding.
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Saturating increment shared by all 16-bit statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mtg_tracker.sv
// Request tracking: issued/completed bitmaps, response legality and inflight count.
module mtg_tracker #(
    parameter  int ADDR_W       = 64,
    parameter  int MAX_REQS     = 256,
    parameter  int MAX_INFLIGHT = 64,
    parameter  int STRIDE_LOG2  = 6,
    localparam int IDX_W        = $clog2(MAX_REQS),
    localparam int NUM_W        = $clog2(MAX_REQS + 1),
    localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              xfer,
    input  logic [IDX_W-1:0]  xfer_idx,
    input  logic              resp_chk,
    input  logic [ADDR_W-1:0] resp_addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [NUM_W-1:0]  num_reqs,
    output logic              resp_legal,
    output logic              resp_illegal,
    output logic [INF_W-1:0]  inflight
);

    logic [MAX_REQS-1:0] issued_q, issued_d;
    logic [MAX_REQS-1:0] completed_q, completed_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    logic [ADDR_W-1:0]   off;
    logic [ADDR_W-1:0]   k;
    logic [IDX_W-1:0]    k_idx;
    logic                hit;

    // Map the response address back to a request slot and qualify it.
    always_comb begin
        off   = resp_addr - base;
        k     = off >> STRIDE_LOG2;
        k_idx = k[IDX_W-1:0];
        // issued_q is registered, so a response racing its own acceptance is illegal.
        hit   = (off[STRIDE_LOG2-1:0] == '0) && (k < ADDR_W'(num_reqs))
                && issued_q[k_idx] && !completed_q[k_idx];
    end

    assign resp_legal   = resp_chk && hit;
    assign resp_illegal = resp_chk && !hit;
    assign inflight     = inflight_q;

    // Next-state for bitmaps and inflight; simultaneous issue and completion cancel out.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        issued_d    = issued_q;
        completed_d = completed_q;
        inflight_d  = inflight_q;
        if (clear) begin
            issued_d    = '0;
            completed_d = '0;
            inflight_d  = '0;
        end else begin
            if (xfer)       issued_d[xfer_idx] = 1'b1;
            if (resp_legal) completed_d[k_idx] = 1'b1;
            case ({xfer, resp_legal})
                2'b10:   inflight_d = inflight_q + INF_W'(1);
                2'b01:   inflight_d = inflight_q - INF_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // Tracking state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the bitmaps are flops, not RAM, so they take the async reset like any other state.
        if (!rst_n) begin
            issued_q    <= '0;
            completed_q <= '0;
            inflight_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            issued_q    <= issued_d;
            completed_q <= completed_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: rtl/mem_traffic_gen.sv
// Programmable read/write traffic generator with response completion checking.
module mem_traffic_gen
    import mem_traffic_pkg::*;
#(
    parameter  int          ADDR_W       = 64,
    parameter  int          MAX_REQS     = 256,
    parameter  int          MAX_INFLIGHT = 64,
    parameter  int          STRIDE_LOG2  = 6,
    parameter  int          STALL_LIMIT  = 10000,
    parameter  int          DRAIN_LIMIT  = 50000,
    parameter  logic [31:0] SRC_ID       = 32'h0,
    localparam int          NUM_W        = $clog2(MAX_REQS + 1),
    localparam int          INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [NUM_W-1:0]  cfg_num_reqs,
    input  logic [INF_W-1:0]  cfg_inflight,
    input  logic [7:0]        cfg_wr_every,
    input  logic              init_done,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_type,
    output logic [31:0]       req_source_id,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [ADDR_W-1:0] resp_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_code,
    output logic [15:0]       cnt_accepted,
    output logic [15:0]       cnt_rejected,
    output logic [15:0]       cnt_completed
);

    localparam int IDX_W   = $clog2(MAX_REQS);
    localparam int STALL_W = $clog2(STALL_LIMIT + 3);
    localparam int DRAIN_W = $clog2(DRAIN_LIMIT + 2);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_LIMIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [NUM_W-1:0]    idx_q, idx_d;
    logic [INF_W-1:0]    lim_q, lim_d;
    logic [7:0]          wr_every_q, wr_every_d;
    logic [7:0]          wr_ph_q, wr_ph_d;   // idx modulo wr_every, kept incrementally
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [2:0]          err_q, err_d;
    logic [15:0]         acc_q, acc_d, rej_q, rej_d, cmp_q, cmp_d;
    logic                done_q, done_d, pass_q, pass_d;
    logic [INF_W-1:0]    inflight;
    logic                resp_legal, resp_illegal, xfer, resp_chk, trk_clear;

    assign req_valid     = (state_q == ISSUE) && (idx_q < num_q) && (inflight < lim_q);
    assign req_addr      = base_q + (ADDR_W'(idx_q) << STRIDE_LOG2);
    assign req_type      = ((wr_every_q != 8'd0) && (wr_ph_q == 8'd0)) ? WR : RD;
    assign req_source_id = SRC_ID;
    assign busy          = state_q inside {WAIT_INIT, ISSUE, DRAIN};
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_code      = err_q;
    assign cnt_accepted  = acc_q;
    assign cnt_rejected  = rej_q;
    assign cnt_completed = cmp_q;

    assign xfer      = req_valid && req_ready;
    assign resp_chk  = resp_valid && (state_q inside {ISSUE, DRAIN});
    assign trk_clear = (state_q == IDLE) && start;

    mtg_tracker #(
        .ADDR_W      (ADDR_W),
        .MAX_REQS    (MAX_REQS),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .STRIDE_LOG2 (STRIDE_LOG2)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (trk_clear),
        .xfer        (xfer),
        .xfer_idx    (idx_q[IDX_W-1:0]),
        .resp_chk    (resp_chk),
        .resp_addr   (resp_addr),
        .base        (base_q),
        .num_reqs    (num_q),
        .resp_legal  (resp_legal),
        .resp_illegal(resp_illegal),
        .inflight    (inflight)
    );

    // Run sequencing, issue bookkeeping, counters and error flags.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        idx_d      = idx_q;
        lim_d      = lim_q;
        wr_every_d = wr_every_q;
        wr_ph_d    = wr_ph_q;
        stall_d    = stall_q;
        drain_d    = drain_q;
        err_d      = err_q;
        acc_d      = acc_q;
        rej_d      = rej_q;
        cmp_d      = cmp_q;
        done_d     = done_q;
        pass_d     = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_INIT;
                    base_d     = cfg_base;
                    num_d      = cfg_num_reqs;
                    lim_d      = cfg_inflight;
                    wr_every_d = cfg_wr_every;
                    wr_ph_d    = '0;
                    idx_d      = '0;
                    stall_d    = '0;
                    drain_d    = '0;
                    err_d      = '0;
                    acc_d      = '0;
                    rej_d      = '0;
                    cmp_d      = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            WAIT_INIT: begin
                if (init_done) state_d = ISSUE;
            end
            ISSUE: begin
                if (xfer) begin
                    idx_d   = idx_q + NUM_W'(1);
                    wr_ph_d = (wr_ph_q + 8'd1 == wr_every_q) ? 8'd0 : wr_ph_q + 8'd1;
                    acc_d   = sat_inc(acc_q);
                    stall_d = '0;
                end else if (req_valid) begin
                    rej_d   = sat_inc(rej_q);
                    stall_d = stall_q + STALL_W'(1);
                end
                if (stall_q > STALL_MAX) begin
                    err_d[ERR_STALL] = 1'b1;
                    state_d          = DONE;
                end else if (idx_q == num_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (cmp_q == acc_q) begin
                    state_d = DONE;
                end else if (drain_q == DRAIN_MAX) begin
                    err_d[ERR_DRAIN] = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == 3'b000) && (cmp_q == 16'(num_q));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (resp_legal)   cmp_d           = sat_inc(cmp_q);
        if (resp_illegal) err_d[ERR_RESP] = 1'b1;
    end

    // Control and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            lim_q      <= '0;
            wr_every_q <= '0;
            wr_ph_q    <= '0;
            stall_q    <= '0;
            drain_q    <= '0;
            err_q      <= '0;
            acc_q      <= '0;
            rej_q      <= '0;
            cmp_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            lim_q      <= lim_d;
            wr_every_q <= wr_every_d;
            wr_ph_q    <= wr_ph_d;
            stall_q    <= stall_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            cmp_q      <= cmp_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Self-checking bench: memory responder model plus directed and random runs.
module tb_mem_traffic_gen;

    localparam int NUM_W = $clog2(256 + 1);
    localparam int INF_W = $clog2(64 + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [63:0]       cfg_base;
    logic [NUM_W-1:0]  cfg_num_reqs;
    logic [INF_W-1:0]  cfg_inflight;
    logic [7:0]        cfg_wr_every;
    logic              init_done;
    logic              req_valid;
    logic [63:0]       req_addr;
    logic              req_type;
    logic [31:0]       req_source_id;
    logic              req_ready;
    logic              resp_valid;
    logic [63:0]       resp_addr;
    logic              busy, done, pass;
    logic [2:0]        err_code;
    logic [15:0]       cnt_accepted, cnt_rejected, cnt_completed;

    mem_traffic_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base),
        .cfg_num_reqs(cfg_num_reqs), .cfg_inflight(cfg_inflight), .cfg_wr_every(cfg_wr_every),
        .init_done(init_done), .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type),
        .req_source_id(req_source_id), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_addr(resp_addr), .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .cnt_accepted(cnt_accepted), .cnt_rejected(cnt_rejected), .cnt_completed(cnt_completed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [63:0] m_base;
    int          m_n, m_lim, m_wr, m_lat_lo, m_lat_hi;
    int          m_acc, m_resp, m_rej, m_wr_cnt;
    int          ready_mode, resp_allow;
    logic        inj_pending;
    logic [63:0] inj_addr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // One clock: choose ready, observe handshakes, drive one response from the model.
    task automatic step();
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0:       req_ready = 1'b1;
            1:       req_ready = ($urandom_range(0, 3) != 0);
            default: req_ready = (m_acc == 0);
        endcase
        if (req_valid) begin
            check("inflight_cap", ((m_acc - m_resp) < m_lim), 1);
            if (req_ready) begin
                check("req_addr", req_addr, m_base + (64'(m_acc) << 6));
                check("req_type", req_type, (m_wr != 0) && (m_acc % m_wr == 0));
                if (req_type) m_wr_cnt++;
                pend.push_back('{addr: m_base + (64'(m_acc) << 6),
                                 due: cyc + $urandom_range(m_lat_lo, m_lat_hi)});
                m_acc++;
            end else begin
                m_rej++;
            end
        end
        resp_valid = 1'b0;
        if (inj_pending) begin
            resp_valid  = 1'b1;
            resp_addr   = inj_addr;
            inj_pending = 1'b0;
        end else if (resp_allow > 0 && pend.size() > 0) begin
            int sel;
            sel = (m_lat_lo == m_lat_hi) ? 0 : $urandom_range(0, pend.size() - 1);
            if (pend[sel].due <= cyc) begin
                resp_valid = 1'b1;
                resp_addr  = pend[sel].addr;
                pend.delete(sel);
                m_resp++;
                resp_allow--;
            end
        end
    endtask

    task automatic start_run(input logic [63:0] base, input int n, input int lim, input int wr,
                             input int lat_lo, input int lat_hi, input int rmode);
        m_base = base; m_n = n; m_lim = lim; m_wr = wr;
        m_lat_lo = lat_lo; m_lat_hi = lat_hi;
        m_acc = 0; m_resp = 0; m_rej = 0; m_wr_cnt = 0;
        pend.delete();
        ready_mode = rmode;
        resp_allow = 1 << 30;
        cfg_base = base; cfg_num_reqs = NUM_W'(n); cfg_inflight = INF_W'(lim);
        cfg_wr_every = 8'(wr);
        start = 1'b1; init_done = 1'b0;
        step();
        start = 1'b0;
        // Configuration changes after start must not affect the run.
        cfg_base = {$urandom(), $urandom()}; cfg_num_reqs = NUM_W'($urandom());
        cfg_inflight = INF_W'($urandom()); cfg_wr_every = 8'($urandom());
        step(); step();
        init_done = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic final_checks(input string tag, input logic exp_pass, input logic [2:0] exp_err,
                                input int exp_acc, input int exp_cmp);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_err"}, err_code, exp_err);
        check({tag, "_acc"}, cnt_accepted, exp_acc);
        check({tag, "_cmp"}, cnt_completed, exp_cmp);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; init_done = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_addr = '0; cfg_base = '0; cfg_num_reqs = '0;
        cfg_inflight = '0; cfg_wr_every = '0; inj_pending = 1'b0; inj_addr = '0;
        ready_mode = 0; resp_allow = 0; m_lim = 1; m_acc = 0; m_resp = 0;
        m_base = '0; m_wr = 0; m_lat_lo = 1; m_lat_hi = 1;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_req_valid", req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_code, 0);
        check("rst_counters", {cnt_accepted, cnt_rejected, cnt_completed}, 0);
        check("rst_addr_type_src", {req_addr[31:0], req_source_id, 31'b0, req_type}, 0);
        rst_n = 1'b1;
        step();

        // Ideal memory: 128 requests, every 4th a write, fixed 20-cycle latency.
        start_run(64'h0, 128, 64, 4, 20, 20, 0);
        wait_done("t1", 600);
        final_checks("t1", 1, 3'b000, 128, 128);
        check("t1_rej", cnt_rejected, 0);
        check("t1_writes", m_wr_cnt, 32);

        // Inflight limit 2 with responses withheld.
        start_run(64'h4000, 8, 2, 0, 1, 1, 0);
        resp_allow = 0;
        repeat (12) step();
        check("t2_acc_hold", cnt_accepted, 2);
        check("t2_valid_low", req_valid, 0);
        check("t2_busy", busy, 1);
        resp_allow = 1;
        repeat (6) step();
        check("t2_acc_one_more", cnt_accepted, 3);
        check("t2_valid_low2", req_valid, 0);
        check("t2_cmp", cnt_completed, 1);
        resp_allow = 1 << 30;
        wait_done("t2", 200);
        final_checks("t2", 1, 3'b000, 8, 8);

        // Stall timeout: ready stays low after the first accept.
        start_run(64'h0, 4, 64, 0, 20, 20, 2);
        wait_done("t3", 10200);
        final_checks("t3", 0, 3'b001, 1, 1);
        check("t3_rej_min", cnt_rejected >= 16'd10001, 1);

        // Response for a never-issued slot (k = 125) during ISSUE.
        start_run(64'h0, 128, 64, 4, 20, 20, 0);
        for (int k = 0; k < 100 && m_acc < 5; k++) step();
        inj_addr = 64'h1F40; inj_pending = 1'b1;
        step(); step();
        check("t4_err_now", err_code, 3'b100);
        check("t4_cmp_now", cnt_completed, 0);
        wait_done("t4", 600);
        final_checks("t4", 0, 3'b100, 128, 128);

        // Duplicate response for 0x40.
        start_run(64'h0, 16, 64, 0, 10, 10, 0);
        for (int k = 0; k < 100 && m_resp < 3; k++) step();
        inj_addr = 64'h40; inj_pending = 1'b1;
        step(); step();
        check("t5_dup_err", err_code, 3'b100);
        wait_done("t5", 200);
        final_checks("t5", 0, 3'b100, 16, 16);

        // Misaligned response address 0x44.
        start_run(64'h0, 16, 64, 0, 10, 10, 0);
        for (int k = 0; k < 100 && m_acc < 3; k++) step();
        inj_addr = 64'h44; inj_pending = 1'b1;
        step(); step();
        check("t5b_mis_err", err_code, 3'b100);
        check("t5b_cmp_now", cnt_completed, 0);
        wait_done("t5b", 200);
        final_checks("t5b", 0, 3'b100, 16, 16);

        // Asynchronous reset in the middle of ISSUE, then a clean run.
        start_run(64'h0, 64, 8, 3, 1, 8, 1);
        for (int k = 0; k < 200 && m_acc < 10; k++) step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", req_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_counters", {cnt_accepted, cnt_rejected, cnt_completed}, 0);
        check("t6_err_addr", {err_code, req_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_valid = 1'b0;
        pend.delete();
        check("t6_no_done", done, 0);
        start_run(64'h1000, 20, 4, 2, 1, 6, 1);
        wait_done("t6", 400);
        final_checks("t6", 1, 3'b000, 20, 20);

        // Boundary runs and randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            logic [63:0] b;
            int n, lim, wr, exp_wr;
            b = {$urandom(), $urandom()} & ~64'h3F;
            case (r)
                0:       begin n = 1;   lim = 1;  wr = 1; end
                1:       begin n = 256; lim = 64; wr = 0; end
                default: begin
                    n = $urandom_range(1, 48); lim = $urandom_range(1, 8); wr = $urandom_range(0, 5);
                end
            endcase
            exp_wr = (wr == 0) ? 0 : (n - 1) / wr + 1;
            start_run(b, n, lim, wr, 1, 12, 1);
            wait_done("rnd", 4000);
            final_checks("rnd", 1, 3'b000, n, n);
            check("rnd_rej", cnt_rejected, m_rej);
            check("rnd_writes", m_wr_cnt, exp_wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_traffic_gen.md
Name: mem_traffic_gen

Overview:
- Synthesizable, parametrised traffic generator and completion checker for the ramulator_sv_wrapper request/response interface.
- Generates a programmable read/write address stream and limits the number of outstanding requests.
- Matches each response to its request by address, detects protocol errors, and reports pass/fail with counters.
- Sits between a control/CSR block and ramulator_sv_wrapper so smoke and stress runs need no behavioural bench code.

Parameters:
- ADDR_W, 64, request/response address width.
- MAX_REQS, 256, upper bound on requests per run; sizes the tracking bitmap.
- MAX_INFLIGHT, 64, hardware ceiling on outstanding requests.
- STRIDE_LOG2, 6, log2 of the address stride (64-byte line).
- STALL_LIMIT, 10000, maximum consecutive cycles with req_valid high and req_ready low.
- DRAIN_LIMIT, 50000, maximum cycles allowed in DRAIN.
- SRC_ID, 32'h0, constant value driven on req_source_id.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that launches a run
- cfg_base  in  ADDR_W  base address, must be stride-aligned
- cfg_num_reqs  in  $clog2(MAX_REQS+1)  requests in the run, 1..MAX_REQS
- cfg_inflight  in  $clog2(MAX_INFLIGHT+1)  run-time inflight limit, 1..MAX_INFLIGHT
- cfg_wr_every  in  8  every Nth request is a write; 0 means all reads
- init_done  in  1  readiness indication from the wrapper
- req_valid  out  1  request valid
- req_addr  out  ADDR_W  request address
- req_type  out  1  request type, 0=read, 1=write
- req_source_id  out  32  request source id
- req_ready  in  1  request ready
- resp_valid  in  1  response valid
- resp_addr  in  ADDR_W  response address
- busy  out  1  run in progress
- done  out  1  run finished; held until the next start
- pass  out  1  run result; valid while done is high
- err_code  out  3  error flags: bit0 stall timeout, bit1 drain timeout, bit2 unexpected response
- cnt_accepted  out  16  accepted requests
- cnt_rejected  out  16  request cycles with valid high and ready low
- cnt_completed  out  16  matched responses

Behaviour:
- Reset, asynchronous:
  - State = IDLE.
  - All outputs are 0, the tracking bitmaps are cleared, and inflight = 0.
  - Reset asserted mid-run aborts the run immediately; no done pulse is produced.
- Configuration inputs are captured at start. Later changes to them have no effect on the run in progress.
- State machine:
  - IDLE: on start, go to WAIT_INIT. Set busy = 1, done = 0, and clear the counters, bitmaps and err_code.
  - WAIT_INIT: wait for init_done = 1, then go to ISSUE on the next cycle.
  - ISSUE:
    - req_valid = 1 when idx < num_reqs and inflight < cfg_inflight.
    - req_addr = base + (idx << STRIDE_LOG2).
    - req_type = 1 when cfg_wr_every != 0 and idx % cfg_wr_every == 0.
    - A request transfers when req_valid and req_ready are both 1 at a posedge. On transfer: set issued[idx], increment idx, increment inflight, increment cnt_accepted, clear the stall counter.
    - A cycle with req_valid = 1 and req_ready = 0 increments cnt_rejected and the stall counter. req_addr and req_type hold stable until the transfer.
    - When idx == num_reqs, go to DRAIN.
    - When the stall counter exceeds STALL_LIMIT, set err bit0 and go to DONE.
  - DRAIN: req_valid = 0.
    - When cnt_completed == cnt_accepted, go to DONE.
    - When the drain counter reaches DRAIN_LIMIT, set err bit1 and go to DONE.
  - DONE: busy = 0, done = 1, pass = (err_code == 0 and cnt_completed == num_reqs). Go to IDLE the same cycle.
- Response checking, active in ISSUE and DRAIN:
  - off = resp_addr - base; k = off >> STRIDE_LOG2.
  - A response is legal when the low STRIDE_LOG2 bits of off are zero, k < num_reqs, issued[k] = 1, and completed[k] = 0.
  - Legal response: set completed[k], decrement inflight, increment cnt_completed.
  - Illegal response: set err bit2 (sticky); no counters change. A response received in IDLE or DONE is ignored.
- Simultaneous transfer and legal response in the same cycle: inflight is unchanged.
- A response may arrive in the same cycle as the acceptance of its own request; that case is illegal and sets bit2.
- Counters saturate at 16'hFFFF.
- start while busy is ignored.

Decomposition:
- Package mem_traffic_pkg:
  - state enum: IDLE, WAIT_INIT, ISSUE, DRAIN, DONE.
  - err_code bit-index localparams.
  - req_type encoding constants RD = 0, WR = 1.
- Sub-module mtg_tracker: issued/completed bitmaps, the legality check and the inflight counter, parametrised on MAX_REQS and MAX_INFLIGHT.

Test Plan:
- base = 0, num_reqs = 128, inflight = 64, wr_every = 4; ideal memory with ready = 1 and a fixed 20-cycle response latency:
  - accepted = 128, completed = 128, rejected = 0, pass = 1.
  - Exactly 32 writes, at addresses 0x0, 0x100, ...
- cfg_inflight = 2, responses held back: req_valid drops after 2 accepts. Release one response → exactly one further accept follows.
- req_ready held low for 10001 cycles after the first accept → err_code = 3'b001, done = 1, pass = 0.
- Inject a response at 0x1F40 (k = 125, never issued) during ISSUE → err bit2 set, cnt_completed unchanged, pass = 0.
- Duplicate response for address 0x40 → err bit2 set. Separately, a misaligned resp_addr 0x44 → err bit2 set.
- Drop rst_n low for 1 cycle mid-ISSUE → all outputs return to 0 asynchronously. A subsequent start runs to completion with pass = 1.
